// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmit path: FSM encoding, parity types, default width.
package uart_tx_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 8;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Host-side byte handshake for the UART transmitter: request, payload, frame config and busy.
interface uart_tx_ctrl_if
   import uart_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  DATA_VALID;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic                  busy;

   modport master (output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, input busy);
   modport slave  (input P_DATA, DATA_VALID, PAR_EN, PAR_TYP, output busy);
endinterface

// File: rtl/uart_tx_bit_timer.sv
// Prescale counter (bit_tick on the last clock of each serial bit) and data-bit index counter.
module uart_tx_bit_timer
   import uart_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned PRESCALE   = 1,
   localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1,
   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          bit_cnt_en,
   output logic          bit_tick,
   output logic [BW-1:0] bit_cnt,
   output logic          last_bit
);
   logic [PW-1:0] pre_cnt;

   assign bit_tick = (pre_cnt == PW'(PRESCALE - 1));
   assign last_bit = (bit_cnt == BW'(DATA_WIDTH - 1));

   // start realigns the prescaler so the first bit of a frame gets a full PRESCALE clocks
   always_ff @(posedge clk) begin
      if (rst || start) begin
         pre_cnt <= '0;
         bit_cnt <= '0;
      end else begin
         pre_cnt <= bit_tick ? '0 : pre_cnt + PW'(1);
         if (bit_cnt_en && bit_tick)
            bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
      end
   end
endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: latches byte/config, pulses parity_calc, serializes start/data/parity/stop.
module uart_tx_ctrl
   import uart_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned PRESCALE   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   uart_tx_ctrl_if.slave         host,
   input  logic                  PAR_BIT,
   output logic [DATA_WIDTH-1:0] par_data,
   output logic                  par_typ,
   output logic                  par_calc_en,
   output logic                  TX_OUT
);
   localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic [2:0]    state;
   logic          par_en_q;
   logic          start;
   logic          bit_tick;
   logic          last_bit;
   logic [BW-1:0] bit_cnt;
   logic [BW-1:0] nxt_idx;

   assign start   = (state == IDLE) && host.DATA_VALID;
   assign nxt_idx = bit_cnt + BW'(1);

   uart_tx_bit_timer #(
      .DATA_WIDTH (DATA_WIDTH),
      .PRESCALE   (PRESCALE)
   ) u_bit_timer (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .bit_cnt_en (state == DATA),
      .bit_tick   (bit_tick),
      .bit_cnt    (bit_cnt),
      .last_bit   (last_bit)
   );

   // TX_OUT is registered, so each transition loads the value of the bit being entered
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         TX_OUT      <= 1'b1;
         host.busy   <= 1'b0;
         par_calc_en <= 1'b0;
         par_data    <= '0;
         par_typ     <= 1'b0;
         par_en_q    <= 1'b0;
      end else begin
         par_calc_en <= 1'b0;
         case (state)
            IDLE: if (host.DATA_VALID) begin
               state       <= START;
               par_data    <= host.P_DATA;
               par_typ     <= host.PAR_TYP;
               par_en_q    <= host.PAR_EN;
               host.busy   <= 1'b1;
               TX_OUT      <= 1'b0;
               par_calc_en <= 1'b1;
            end
            START: if (bit_tick) begin
               state  <= DATA;
               TX_OUT <= par_data[0];
            end
            DATA: if (bit_tick) begin
               if (!last_bit) begin
                  TX_OUT <= par_data[nxt_idx];
               end else if (par_en_q) begin
                  state  <= PARITY;
                  TX_OUT <= PAR_BIT;
               end else begin
                  state  <= STOP;
                  TX_OUT <= 1'b1;
               end
            end
            PARITY: if (bit_tick) begin
               state  <= STOP;
               TX_OUT <= 1'b1;
            end
            STOP: if (bit_tick) begin
               state     <= IDLE;
               host.busy <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               TX_OUT    <= 1'b1;
               host.busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: PRESCALE=1 and PRESCALE=4 instances with a parity_calc model each.
module tb_uart_tx_ctrl;
   import uart_tx_pkg::*;

   typedef struct packed {
      logic tx;
      logic busy;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       dv1 = 1'b0, dv4 = 1'b0;
   logic [7:0] pdata = '0;
   logic       pen = 1'b0, ptyp = 1'b0;

   uart_tx_ctrl_if #(.DATA_WIDTH(8)) if1 ();
   uart_tx_ctrl_if #(.DATA_WIDTH(8)) if4 ();

   assign if1.DATA_VALID = dv1;
   assign if1.P_DATA     = pdata;
   assign if1.PAR_EN     = pen;
   assign if1.PAR_TYP    = ptyp;
   assign if4.DATA_VALID = dv4;
   assign if4.P_DATA     = pdata;
   assign if4.PAR_EN     = pen;
   assign if4.PAR_TYP    = ptyp;

   logic [7:0] pd1, pd4;
   logic       pt1, pt4, pce1, pce4, tx1, tx4, pb1, pb4;

   uart_tx_ctrl #(.DATA_WIDTH(8), .PRESCALE(1)) u_dut1 (
      .clk(clk), .rst(rst), .host(if1), .PAR_BIT(pb1),
      .par_data(pd1), .par_typ(pt1), .par_calc_en(pce1), .TX_OUT(tx1)
   );

   uart_tx_ctrl #(.DATA_WIDTH(8), .PRESCALE(4)) u_dut4 (
      .clk(clk), .rst(rst), .host(if4), .PAR_BIT(pb4),
      .par_data(pd4), .par_typ(pt4), .par_calc_en(pce4), .TX_OUT(tx4)
   );

   // external parity_calc stand-in: registers parity of the latched byte on each enable pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         pb1 <= 1'b0;
         pb4 <= 1'b0;
      end else begin
         if (pce1) pb1 <= (^pd1) ^ (pt1 == PAR_ODD);
         if (pce4) pb4 <= (^pd4) ^ (pt4 == PAR_ODD);
      end
   end

   int   errors = 0;
   int   checks = 0;
   exp_t q[$];

   task automatic push_bit(int ps, logic b, logic bsy);
      exp_t e;
      e.tx   = b;
      e.busy = bsy;
      for (int k = 0; k < ps; k++) q.push_back(e);
   endtask

   task automatic push_frame(int ps, logic [7:0] d, logic pe, logic pt);
      push_bit(ps, 1'b0, 1'b1);
      for (int k = 0; k < 8; k++) push_bit(ps, d[k], 1'b1);
      if (pe) push_bit(ps, (^d) ^ (pt == PAR_ODD), 1'b1);
      push_bit(ps, 1'b1, 1'b1);
   endtask

   task automatic start_frame(int ps, logic [7:0] d, logic pe, logic pt);
      pdata = d;
      pen   = pe;
      ptyp  = pt;
      if (ps == 4) dv4 = 1'b1; else dv1 = 1'b1;
   endtask

   // inj_kind 1: mid-frame request with altered inputs; 2: reset pulse
   task automatic play(int ps, int drop_at, int inj_at, int inj_kind, output int pulses);
      pulses = 0;
      for (int i = 0; q.size() > 0; i++) begin
         exp_t e;
         logic otx, obusy, opce;
         @(negedge clk);
         if (i == drop_at) begin dv1 = 1'b0; dv4 = 1'b0; end
         otx   = (ps == 4) ? tx4 : tx1;
         obusy = (ps == 4) ? if4.busy : if1.busy;
         opce  = (ps == 4) ? pce4 : pce1;
         e = q.pop_front();
         checks++;
         if (otx !== e.tx) begin
            errors++;
            $display("FAIL tx_out ps=%0d idx=%0d got=%b exp=%b", ps, i, otx, e.tx);
         end
         checks++;
         if (obusy !== e.busy) begin
            errors++;
            $display("FAIL busy ps=%0d idx=%0d got=%b exp=%b", ps, i, obusy, e.busy);
         end
         if (opce === 1'b1) pulses++;
         if (inj_kind == 1 && i == inj_at) begin
            pdata = 8'hFF;
            ptyp  = ~ptyp;
            pen   = ~pen;
            if (ps == 4) dv4 = 1'b1; else dv1 = 1'b1;
         end
         if (inj_kind == 1 && i == inj_at + 2) begin dv1 = 1'b0; dv4 = 1'b0; end
         if (inj_kind == 2 && i == inj_at) begin
            rst = 1'b1;
            @(negedge clk);
            otx   = (ps == 4) ? tx4 : tx1;
            obusy = (ps == 4) ? if4.busy : if1.busy;
            opce  = (ps == 4) ? pce4 : pce1;
            checks++;
            if (otx !== 1'b1 || obusy !== 1'b0 || opce !== 1'b0) begin
               errors++;
               $display("FAIL midframe_reset got tx=%b busy=%b pce=%b exp tx=1 busy=0 pce=0",
                        otx, obusy, opce);
            end
            rst = 1'b0;
            q.delete();
         end
      end
   endtask

   task automatic check_idle(int ps, int n);
      for (int i = 0; i < n; i++) begin
         logic otx, obusy;
         @(negedge clk);
         otx   = (ps == 4) ? tx4 : tx1;
         obusy = (ps == 4) ? if4.busy : if1.busy;
         checks++;
         if (otx !== 1'b1 || obusy !== 1'b0) begin
            errors++;
            $display("FAIL idle ps=%0d cyc=%0d got tx=%b busy=%b exp tx=1 busy=0", ps, i, otx, obusy);
         end
      end
   endtask

   task automatic check_pulses(string name, int got, int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s par_calc_en cycles got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (tx1 !== 1'b1 || if1.busy !== 1'b0 || pce1 !== 1'b0 || pd1 !== 8'h00 || pt1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_ps1 got tx=%b busy=%b pce=%b pd=%h pt=%b exp 1 0 0 00 0",
                  tx1, if1.busy, pce1, pd1, pt1);
      end
      checks++;
      if (tx4 !== 1'b1 || if4.busy !== 1'b0 || pce4 !== 1'b0 || pd4 !== 8'h00 || pt4 !== 1'b0) begin
         errors++;
         $display("FAIL reset_ps4 got tx=%b busy=%b pce=%b pd=%h pt=%b exp 1 0 0 00 0",
                  tx4, if4.busy, pce4, pd4, pt4);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_parity_odd();
      int p;
      push_frame(1, 8'hC0, 1'b1, PAR_ODD);
      start_frame(1, 8'hC0, 1'b1, PAR_ODD);
      play(1, 0, -10, 0, p);
      check_pulses("parity_odd", p, 1);
      check_idle(1, 2);
   endtask

   task automatic test_parity_even();
      int p;
      push_frame(1, 8'h80, 1'b1, PAR_EVEN);
      start_frame(1, 8'h80, 1'b1, PAR_EVEN);
      play(1, 0, -10, 0, p);
      check_pulses("parity_even", p, 1);
      check_idle(1, 1);
      push_frame(1, 8'h80, 1'b1, PAR_ODD);
      start_frame(1, 8'h80, 1'b1, PAR_ODD);
      play(1, 0, -10, 0, p);
      check_pulses("parity_odd_80", p, 1);
      checks++;
      if (pt1 !== PAR_ODD) begin
         errors++;
         $display("FAIL par_typ_latch got=%b exp=%b", pt1, PAR_ODD);
      end
      check_idle(1, 1);
   endtask

   task automatic test_prescale();
      int p;
      push_frame(4, 8'hA5, 1'b0, PAR_EVEN);
      start_frame(4, 8'hA5, 1'b0, PAR_EVEN);
      play(4, 0, -10, 0, p);
      check_pulses("prescale", p, 1);
      check_idle(4, 2);
   endtask

   task automatic test_ignore_busy();
      int p;
      push_frame(4, 8'h3C, 1'b1, PAR_EVEN);
      start_frame(4, 8'h3C, 1'b1, PAR_EVEN);
      play(4, 0, 10, 1, p);
      check_pulses("ignore_busy", p, 1);
      checks++;
      if (pd4 !== 8'h3C || pt4 !== PAR_EVEN) begin
         errors++;
         $display("FAIL latched_cfg got pd=%h pt=%b exp pd=3c pt=0", pd4, pt4);
      end
      check_idle(4, 8);
   endtask

   task automatic test_reset_midframe();
      int p;
      push_frame(1, 8'h0F, 1'b1, PAR_ODD);
      start_frame(1, 8'h0F, 1'b1, PAR_ODD);
      play(1, 0, 4, 2, p);
      check_idle(1, 2);
      push_frame(1, 8'h55, 1'b1, PAR_EVEN);
      start_frame(1, 8'h55, 1'b1, PAR_EVEN);
      play(1, 0, -10, 0, p);
      check_pulses("after_reset", p, 1);
      check_idle(1, 1);
   endtask

   task automatic test_back_to_back();
      int p;
      for (int f = 0; f < 3; f++) begin
         push_frame(1, 8'h96, 1'b1, PAR_ODD);
         if (f < 2) push_bit(1, 1'b1, 1'b0);
      end
      start_frame(1, 8'h96, 1'b1, PAR_ODD);
      play(1, 25, -10, 0, p);
      check_pulses("back_to_back", p, 3);
      check_idle(1, 3);
   endtask

   initial begin
      test_reset();
      test_parity_odd();
      test_parity_even();
      test_prescale();
      test_ignore_busy();
      test_reset_midframe();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end
endmodule
